// File: rtl/cpu_pkg.sv
// Shared processor definitions: opcodes, sequencer states, ALU codes.
// Reused by the control sequencer and by processor-level decode.
package cpu_pkg;

    localparam int OPC_W  = 4;
    localparam int ALU_W  = 3;
    localparam int WAIT_W = 16;

    // Instruction opcodes (instr[15:12])
    localparam logic [OPC_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OPC_W-1:0] OP_AND  = 4'b0010;
    localparam logic [OPC_W-1:0] OP_OR   = 4'b0011;
    localparam logic [OPC_W-1:0] OP_LW   = 4'b0100;
    localparam logic [OPC_W-1:0] OP_SW   = 4'b0101;
    localparam logic [OPC_W-1:0] OP_BEQ  = 4'b0110;
    localparam logic [OPC_W-1:0] OP_HALT = 4'b1111;

    // ALU operation codes
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;

    // Sequencer states; code 7 is never entered
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    function automatic logic is_rtype(input logic [OPC_W-1:0] op);
        return op[3:2] == 2'b00;
    endfunction

    function automatic logic is_mem(input logic [OPC_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // Opcodes that go on to EXEC (HALT is handled separately)
    function automatic logic is_exec(input logic [OPC_W-1:0] op);
        return is_rtype(op) || is_mem(op) || (op == OP_BEQ);
    endfunction

    // R-types pass their low bits through; address calc adds; compare subtracts
    function automatic logic [ALU_W-1:0] alu_for(input logic [OPC_W-1:0] op);
        logic [ALU_W-1:0] r;
        r = ALU_ADD;
        if (is_rtype(op)) begin
            r = op[2:0];
        end else if (op == OP_BEQ) begin
            r = ALU_SUB;
        end
        return r;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts wait cycles of an outstanding memory request.
// expired flags that the current waiting cycle is the limit-th one.
module wait_timer
    import cpu_pkg::*;
#(
    parameter int W = WAIT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         tick,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear has priority; counting saturates so a zero limit never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (limit != '0) && (cnt_q >= limit - 1'b1);

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch, decode, execute, memory, writeback.
// Drives datapath strobes and counts retired instructions.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int ICOUNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         instr,
    output logic                imem_req,
    input  logic                imem_ack,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ack,
    input  logic                alu_zero,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                pc_branch,
    output logic [ALU_W-1:0]    alu_op,
    output logic                branch_enable,
    output logic                write_enable,
    output logic                wb_sel,
    output logic                halted,
    output logic                error,
    output logic [2:0]          state,
    output logic [ICOUNT_W-1:0] instr_count
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);

    state_e              state_q;
    state_e              state_d;
    logic [OPC_W-1:0]    opcode_q;
    logic [OPC_W-1:0]    opcode_d;
    logic [ICOUNT_W-1:0] icount_q;
    logic [ICOUNT_W-1:0] icount_d;

    logic retire;
    logic wt_clear;
    logic wt_tick;
    logic wt_expired;

    // Operand fields are consumed by the datapath, not here
    logic unused_fields;
    assign unused_fields = ^instr[11:0];

    wait_timer #(
        .W(WAIT_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (wt_clear),
        .tick    (wt_tick),
        .limit   (LIMIT),
        .expired (wt_expired)
    );

    // Next-state, strobes and retirement for the current state
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_load       = 1'b0;
        pc_inc        = 1'b0;
        pc_branch     = 1'b0;
        alu_op        = ALU_ADD;
        branch_enable = 1'b0;
        write_enable  = 1'b0;
        wb_sel        = 1'b0;
        halted        = 1'b0;
        error         = 1'b0;
        retire        = 1'b0;
        wt_clear      = 1'b1;
        wt_tick       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load  = 1'b1;
                    pc_inc   = 1'b1;
                    opcode_d = instr[15:12];
                    state_d  = ST_DECODE;
                end else begin
                    wt_clear = 1'b0;
                    wt_tick  = 1'b1;
                    if (wt_expired) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DECODE: begin
                if (is_exec(opcode_q)) begin
                    state_d = ST_EXEC;
                end else if (opcode_q == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_EXEC: begin
                alu_op = alu_for(opcode_q);
                if (opcode_q == OP_BEQ) begin
                    branch_enable = 1'b1;
                    pc_branch     = alu_zero;
                    retire        = 1'b1;
                    state_d       = ST_FETCH;
                end else if (is_mem(opcode_q)) begin
                    state_d = ST_MEM;
                end else if (is_rtype(opcode_q)) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode_q == OP_SW);
                if (dmem_ack) begin
                    if (opcode_q == OP_SW) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    wt_clear = 1'b0;
                    wt_tick  = 1'b1;
                    if (wt_expired) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_WB: begin
                write_enable = 1'b1;
                wb_sel       = (opcode_q == OP_LW);
                retire       = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_ERR: begin
                error = 1'b1;
            end
            default: begin
                error   = 1'b1;
                state_d = ST_ERR;
            end
        endcase

        icount_d = retire ? icount_q + 1'b1 : icount_q;
    end

    // State, opcode and retirement counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            opcode_q <= '0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            icount_q <= icount_d;
        end
    end

    assign state       = state_q;
    assign instr_count = icount_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer against a per-instruction
// timing model derived from the instruction-level latency rules.
module tb_control_sequencer;

    localparam int ICW = 10;
    localparam int WL  = 15;

    localparam logic [3:0] T_LW   = 4'h4;
    localparam logic [3:0] T_SW   = 4'h5;
    localparam logic [3:0] T_BEQ  = 4'h6;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [15:0]    instr = '0;
    logic           imem_ack = 1'b0;
    logic           dmem_ack = 1'b0;
    logic           alu_zero = 1'b0;
    logic           imem_req;
    logic           dmem_req;
    logic           dmem_we;
    logic           ir_load;
    logic           pc_inc;
    logic           pc_branch;
    logic [2:0]     alu_op;
    logic           branch_enable;
    logic           write_enable;
    logic           wb_sel;
    logic           halted;
    logic           error;
    logic [2:0]     state;
    logic [ICW-1:0] instr_count;

    int checks = 0;
    int failures = 0;
    logic [ICW-1:0] exp_count = '0;
    int retired = 0;

    control_sequencer #(
        .WAIT_LIMIT (WL),
        .ICOUNT_W   (ICW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instr         (instr),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ack      (dmem_ack),
        .alu_zero      (alu_zero),
        .ir_load       (ir_load),
        .pc_inc        (pc_inc),
        .pc_branch     (pc_branch),
        .alu_op        (alu_op),
        .branch_enable (branch_enable),
        .write_enable  (write_enable),
        .wb_sel        (wb_sel),
        .halted        (halted),
        .error         (error),
        .state         (state),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_alu(input logic [3:0] op);
        logic [2:0] r;
        case (op)
            4'h0: r = 3'd0;
            4'h1: r = 3'd1;
            4'h2: r = 3'd2;
            4'h3: r = 3'd3;
            T_BEQ: r = 3'd1;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    // One clock: drive inputs after the edge, sample at the falling edge
    task automatic cyc(input logic ia, input logic da, input logic rst);
        @(posedge clk);
        #1;
        imem_ack = ia;
        dmem_ack = da;
        reset = rst;
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        exp_count = '0;
    endtask

    // Any strobe or request activity while parked in HALT/ERR
    function automatic logic active();
        return imem_req | dmem_req | dmem_we | ir_load | pc_inc |
               pc_branch | branch_enable | write_enable | wb_sel;
    endfunction

    // Run one retiring instruction with fetch delay di, data delay dd
    task automatic run_instr(input logic [3:0] op, input int di,
                             input int dd, input logic z);
        int fc;
        int mc;
        int ncyc;
        int ir_n;
        int ir_c;
        int pi_n;
        int we_n;
        int we_c;
        int wbs;
        int dr_n;
        int dw_n;
        int be_n;
        int pb_n;
        int hb_n;
        logic [2:0] alu_x;
        bit mem;
        bit wb;
        fc = 0; mc = 0; ir_n = 0; ir_c = 0; pi_n = 0; we_n = 0;
        we_c = 0; wbs = 0; dr_n = 0; dw_n = 0; be_n = 0; pb_n = 0;
        hb_n = 0; alu_x = '0;
        mem = (op == T_LW) || (op == T_SW);
        wb = (op <= 4'h3) || (op == T_LW);
        ncyc = di + 3 + (mem ? dd + 1 : 0) + (wb ? 1 : 0);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            instr = {op, 12'($urandom)};
            alu_zero = z;
            if (c == 1) begin
                check("fetch_entry", 32'(imem_req), 32'd1);
                check("icount", 32'(instr_count), 32'(exp_count));
            end
            if (imem_req) begin
                imem_ack = (fc == di);
                fc++;
            end else begin
                imem_ack = 1'($urandom);
            end
            if (dmem_req) begin
                dmem_ack = (mc == dd);
                mc++;
            end else begin
                dmem_ack = 1'($urandom);
            end
            @(negedge clk);
            if (ir_load) begin ir_n++; ir_c = c; end
            if (pc_inc) pi_n++;
            if (write_enable) begin we_n++; we_c = c; wbs = 32'(wb_sel); end
            if (dmem_req) dr_n++;
            if (dmem_we) dw_n++;
            if (branch_enable) be_n++;
            if (pc_branch) pb_n++;
            if (halted || error) hb_n++;
            if (c == di + 3) alu_x = alu_op;
        end
        exp_count = exp_count + 1'b1;
        retired++;
        check("ir_load_n", ir_n, 1);
        check("ir_cycle", ir_c, di + 1);
        check("pc_inc_n", pi_n, 1);
        check("we_n", we_n, wb ? 1 : 0);
        if (wb) begin
            check("we_cycle", we_c, ncyc);
            check("wb_sel", wbs, (op == T_LW) ? 1 : 0);
        end
        check("dreq_n", dr_n, mem ? dd + 1 : 0);
        check("dwe_n", dw_n, (op == T_SW) ? dd + 1 : 0);
        check("br_en_n", be_n, (op == T_BEQ) ? 1 : 0);
        check("pc_br_n", pb_n, (op == T_BEQ && z) ? 1 : 0);
        check("alu_op", 32'(alu_x), 32'(exp_alu(op)));
        check("no_halt_err", hb_n, 0);
    endtask

    function automatic int rand_delay();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WL - 1)) : 0;
    endfunction

    initial begin
        int bad;
        logic [3:0] op;

        // Reset state
        do_reset();
        check("rst_state", 32'(state), 32'd0);
        check("rst_icount", 32'(instr_count), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_error", 32'(error), 32'd0);

        // Directed latency cases
        run_instr(4'h0, 0, 0, 1'b0);
        run_instr(T_LW, 0, 3, 1'b0);
        run_instr(T_BEQ, 0, 0, 1'b1);
        run_instr(T_BEQ, 0, 0, 1'b0);
        run_instr(4'h1, WL - 1, 0, 1'b0);
        run_instr(T_SW, 0, WL - 1, 1'b0);

        // Random instruction stream, long enough to wrap the counter
        while (retired < (1 << ICW) + 40) begin
            op = 4'($urandom_range(0, 6));
            run_instr(op, rand_delay(), rand_delay(), 1'($urandom));
        end
        cyc(1'b0, 1'b0, 1'b0);
        check("icount_final", 32'(instr_count), 32'(exp_count));

        // Fetch timeout
        do_reset();
        for (int i = 0; i < WL; i++) cyc(1'b0, 1'b0, 1'b0);
        check("fetch_wait_last", 32'(state), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        check("fetch_timeout", 32'(state), 32'd6);
        check("fetch_to_err", 32'(error), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'($urandom), 1'($urandom), 1'b0);
            if (!error || halted || active()) bad++;
        end
        check("err_hold", bad, 0);

        // Data-access timeout
        do_reset();
        instr = 16'h4123;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WL; i++) cyc(1'b0, 1'b0, 1'b0);
        check("mem_wait_last", 32'(state), 32'd3);
        cyc(1'b0, 1'b0, 1'b0);
        check("mem_timeout", 32'(state), 32'd6);

        // Illegal opcode
        do_reset();
        instr = 16'h7abc;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("illegal_decode", 32'(state), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        check("illegal_err", 32'(state), 32'd6);
        check("illegal_error", 32'(error), 32'd1);

        // HALT
        do_reset();
        instr = 16'hf000;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("halt_state", 32'(state), 32'd5);
        check("halt_flag", 32'(halted), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'($urandom), 1'($urandom), 1'b0);
            if (!halted || error || active()) bad++;
        end
        check("halt_hold", bad, 0);
        check("halt_icount", 32'(instr_count), 32'd0);

        // Reset wins over a store ack in MEM
        do_reset();
        instr = 16'h5000;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        check("rmem_state", 32'(state), 32'd3);
        check("rmem_req", 32'(dmem_req), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        check("rmem_fetch", 32'(state), 32'd0);
        check("rmem_dreq", 32'(dmem_req), 32'd0);
        check("rmem_ireq", 32'(imem_req), 32'd1);
        check("rmem_icount", 32'(instr_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC_UNUSED: none; SHALL have parameter WAIT_LIMIT, default 15, max cycles a memory request waits for ack before fault (0 = no timeout).
REQ-002 SHALL have parameter ICOUNT_W, default 16, width of retired-instruction counter.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 instr  in  16  instruction from instruction memory; opcode [15:12].
REQ-006 imem_req  out  1  fetch request; imem_ack  in  1  fetch data valid this cycle.
REQ-007 dmem_req  out  1  data access request; dmem_we  out  1  store when high; dmem_ack  in  1  access complete.
REQ-008 alu_zero  in  1  ALU result zero flag, used by BEQ.
REQ-009 ir_load  out  1  latch instr; pc_inc  out  1  PC += 1; pc_branch  out  1  PC <= branch_address.
REQ-010 alu_op  out  3  ALU operation; branch_enable  out  1  BEQ evaluation cycle.
REQ-011 write_enable  out  1  regfile write strobe; wb_sel  out  1  0 = ALU result, 1 = load data.
REQ-012 halted  out  1; error  out  1; state  out  3  debug; instr_count  out  ICOUNT_W  retired instructions.

Function
REQ-013 SHALL implement FSM FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), HALT(5), ERR(6); code 7 unreachable, treated as ERR.
REQ-014 SHALL decode opcodes: ADD 0000, SUB 0001, AND 0010, OR 0011, LW 0100, SW 0101, BEQ 0110, HALT 1111; all others illegal.
REQ-015 FETCH: imem_req=1; on imem_ack, ir_load=1 and pc_inc=1 in that same cycle, latch opcode, next DECODE.
REQ-016 DECODE: ALU/LW/SW/BEQ -> EXEC; HALT -> HALT; illegal -> ERR; no output strobes.
REQ-017 EXEC: alu_op = opcode[2:0] for ADD..OR, ADD (000) for LW/SW, SUB (001) for BEQ; R-type -> WB; LW/SW -> MEM.
REQ-018 EXEC for BEQ: branch_enable=1, pc_branch=alu_zero, retire, next FETCH.
REQ-019 MEM: dmem_req=1, dmem_we=1 only for SW; on dmem_ack, SW retires -> FETCH, LW -> WB.
REQ-020 WB: write_enable=1 for exactly one cycle, wb_sel=1 for LW else 0, retire, next FETCH.
REQ-021 Latency without wait states: R-type 4 cycles, BEQ 3, SW 4, LW 5.
REQ-022 Wait counter SHALL clear on entry to FETCH/MEM and increment each cycle without ack; reaching WAIT_LIMIT without ack -> ERR.
REQ-023 ack arriving in the same cycle the counter reaches WAIT_LIMIT SHALL be honoured (ack wins).
REQ-024 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-025 instr_count SHALL increment by 1 per retirement, wrapping from all-ones to 0.
REQ-026 HALT: halted=1, all strobes/requests 0, hold until reset; ERR: error=1, same hold.
REQ-027 All strobes SHALL be 0 in any state/condition not listed above.

Reset
REQ-028 On reset SHALL enter FETCH, clear wait counter, opcode, instr_count; halted=0, error=0.
REQ-029 Reset SHALL win over any simultaneous ack; reset mid-MEM or mid-FETCH drops request the following cycle with no retirement.
REQ-030 imem_req SHALL be 1 in the first cycle after reset deasserts (state FETCH).

Structure
REQ-031 Opcode values, state encodings and alu_op codes SHALL live in shared package cpu_pkg, reused by processor decode.
REQ-032 Timeout counter SHALL be sub-module wait_timer (clear, tick, limit -> expired).

Verification
REQ-033 ADD (0x0000-class) with imem_ack immediate -> ir_load/pc_inc cycle 1, write_enable cycle 4 only, instr_count 0->1.
REQ-034 LW with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, write_enable with wb_sel=1 one cycle after ack, total 8 cycles.
REQ-035 BEQ with alu_zero=1 then alu_zero=0 -> branch_enable both times, pc_branch 1 then 0, no write_enable.
REQ-036 WAIT_LIMIT=15, imem_ack never asserted -> ERR after 15 cycles in FETCH, error=1 held; ack at cycle 15 instead -> DECODE.
REQ-037 Opcode 0111 -> ERR after DECODE; opcode 1111 -> halted=1, imem_req stays 0 for 20 cycles.
REQ-038 Reset asserted during MEM with dmem_ack same cycle -> FETCH next, no retirement, instr_count=0; 65536 retirements wrap instr_count to 0.
